// File: rtl/sn74ls449_ctl.sv
// -----------------------------------------------------------------------------
// sn74ls449_ctl
// Sequencer for an SN74LS449-style 4-bit bus transceiver. A request latches
// the direction (wr) and per-bit mask. It then asserts the matching
// active-low enable for HOLD cycles and emits a one-cycle done pulse. On
// B->A transfers it captures the masked A-side value into q.
//
// Optional feature: define SN74LS449_CTL_TURNAROUND_EN to insert a one-cycle
// TURN gap (both enables off) whenever the transfer direction changes from
// the previous completed transfer.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   req   in   transfer request, sampled only in IDLE
//   wr    in   direction, 1 = A->B, 0 = B->A (latched with req)
//   mask  in   [3:0] per-bit participation (latched with req)
//   din   in   [3:0] A-side bus value, captured on B->A transfers
//   gab   out  active-low A->B enable
//   gba   out  active-low B->A enable
//   dir   out  [3:0] per-bit direction to the transceiver
//   q     out  [3:0] capture register
//   busy  out  high while in TURN or DRIVE
//   done  out  one-cycle completion pulse
//
// Parameter
//   HOLD  enable assertion length in cycles (1..15)
//
// States
//   state | meaning
//   IDLE  | waiting for req; enables off; dir holds its last value
//   TURN  | one-cycle bus turnaround gap, both enables off (macro build only)
//   DRIVE | selected enable asserted for HOLD cycles
//   DONE  | enables off, done pulse high, then back to IDLE
// -----------------------------------------------------------------------------
module sn74ls449_ctl #(
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr,
    input  logic [3:0] mask,
    input  logic [3:0] din,
    output logic       gab,
    output logic       gba,
    output logic [3:0] dir,
    output logic [3:0] q,
    output logic       busy,
    output logic       done
);

`ifdef SN74LS449_CTL_TURNAROUND_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_l;
    logic [3:0] mask_l;
`ifdef SN74LS449_CTL_TURNAROUND_EN
    logic       last_wr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_l    <= 1'b0;
            mask_l  <= 4'd0;
            gab     <= 1'b1;
            gba     <= 1'b1;
            dir     <= 4'd0;
            q       <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SN74LS449_CTL_TURNAROUND_EN
            last_wr <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_l   <= wr;
                        mask_l <= mask;
                        // Unmasked bits face the direction that is not enabled,
                        // so they never see an active driver.
                        dir    <= wr ? mask : ~mask;
                        busy   <= 1'b1;
`ifdef SN74LS449_CTL_TURNAROUND_EN
                        if (wr != last_wr) begin
                            state <= TURN;
                        end else begin
                            state <= DRIVE;
                            cnt   <= HOLD_M1;
                            gab   <= ~wr;
                            gba   <= wr;
                        end
`else
                        state <= DRIVE;
                        cnt   <= HOLD_M1;
                        gab   <= ~wr;
                        gba   <= wr;
`endif
                    end
                end
`ifdef SN74LS449_CTL_TURNAROUND_EN
                TURN: begin
                    state <= DRIVE;
                    cnt   <= HOLD_M1;
                    gab   <= ~wr_l;
                    gba   <= wr_l;
                end
`endif
                DRIVE: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        gab   <= 1'b1;
                        gba   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Capture happens while the B->A enable is still active.
                        if (!wr_l) begin
                            q <= (din & mask_l) | (q & ~mask_l);
                        end
`ifdef SN74LS449_CTL_TURNAROUND_EN
                        last_wr <= wr_l;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gab   <= 1'b1;
                    gba   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn74ls449_ctl.sv
module tb_sn74ls449_ctl;

    localparam int HOLD = 2;
`ifdef SN74LS449_CTL_TURNAROUND_EN
    localparam int TURN_EN = 1;
`else
    localparam int TURN_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] mask = 4'd0;
    logic [3:0] din = 4'd0;
    logic       gab, gba, busy, done;
    logic [3:0] dir, q;

    int n_chk = 0;
    int n_pass = 0;

    sn74ls449_ctl #(.HOLD(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .wr   (wr),
        .mask (mask),
        .din  (din),
        .gab  (gab),
        .gba  (gba),
        .dir  (dir),
        .q    (q),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model: per-transfer cycle schedule ----------
    typedef struct packed {
        logic gab;
        logic gba;
        logic busy;
        logic done;
        logic cap;
    } ent_t;

    function automatic ent_t mk(logic a, logic b, logic bz, logic dn, logic cp);
        ent_t e;
        e.gab = a; e.gba = b; e.busy = bz; e.done = dn; e.cap = cp;
        return e;
    endfunction

    ent_t       sched[$];
    ent_t       cur;
    logic       m_gab = 1'b1, m_gba = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    logic [3:0] m_dir = 4'd0, m_q = 4'd0, m_mask = 4'd0;
    logic       m_wr = 1'b0, m_lastwr = 1'b0, m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            sched.delete();
            m_gab = 1'b1; m_gba = 1'b1; m_busy = 1'b0; m_done = 1'b0;
            m_dir = 4'd0; m_q = 4'd0; m_lastwr = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (sched.size() == 0 && req) begin
                m_wr   = wr;
                m_mask = mask;
                for (int i = 0; i < 4; i++) m_dir[i] = mask[i] ? wr : ~wr;
                if (TURN_EN != 0 && wr != m_lastwr) sched.push_back(mk(1, 1, 1, 0, 0));
                for (int k = 0; k < HOLD; k++) sched.push_back(mk(~wr, wr, 1, 0, 0));
                sched.push_back(mk(1, 1, 0, 1, 1));
                sched.push_back(mk(1, 1, 0, 0, 0));
            end
            if (sched.size() != 0) cur = sched.pop_front();
            else cur = mk(1, 1, 0, 0, 0);
            if (cur.cap) begin
                if (!m_wr) m_q = (din & m_mask) | (m_q & ~m_mask);
                m_lastwr = m_wr;
            end
            m_gab = cur.gab; m_gba = cur.gba; m_busy = cur.busy; m_done = cur.done;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("gab", gab, m_gab);
            chk("gba", gba, m_gba);
            chk("dir", dir, m_dir);
            chk("q", q, m_q);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("no_both_low", (!gab && !gba), 0);
        end
    end

    // ---------------- directed transfers with literal expectations ------------
    task automatic xfer(input logic w, input logic [3:0] m, input logic [3:0] d,
                        output int ngab, output int ngba, output int done_at,
                        output int ndone, output logic [3:0] dir_seen);
        ngab = 0; ngba = 0; done_at = -1; ndone = 0; dir_seen = 4'd0;
        req = 1'b1; wr = w; mask = m; din = d;
        @(negedge clk);
        req = 1'b0;
        wr = 1'($urandom);
        mask = 4'($urandom);
        for (int i = 1; i <= 10; i++) begin
            if (!gab) ngab++;
            if (!gba) ngba++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (i == 1) dir_seen = dir;
            @(negedge clk);
        end
    endtask

    int         ngab, ngba, done_at, ndone;
    logic [3:0] dseen;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gab", gab, 1);
        chk("rst_gba", gba, 1);
        chk("rst_dir", dir, 4'b0000);
        chk("rst_q", q, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // A->B, all bits
        xfer(1'b1, 4'b1111, 4'b1010, ngab, ngba, done_at, ndone, dseen);
        chk("ab_ngab", ngab, 2);
        chk("ab_ngba", ngba, 0);
        chk("ab_done_at", done_at, 3 + TURN_EN);
        chk("ab_ndone", ndone, 1);
        chk("ab_dir", dseen, 4'b1111);
        chk("ab_q", q, 4'b0000);

        // B->A, partial mask
        xfer(1'b0, 4'b0101, 4'b1111, ngab, ngba, done_at, ndone, dseen);
        chk("ba_ngab", ngab, 0);
        chk("ba_ngba", ngba, 2);
        chk("ba_done_at", done_at, 3 + TURN_EN);
        chk("ba_ndone", ndone, 1);
        chk("ba_dir", dseen, 4'b1010);
        chk("ba_q", q, 4'b0101);

        // B->A with empty mask: full sequence, q untouched
        xfer(1'b0, 4'b0000, 4'b1111, ngab, ngba, done_at, ndone, dseen);
        chk("m0_ngba", ngba, 2);
        chk("m0_done_at", done_at, 3);
        chk("m0_dir", dseen, 4'b1111);
        chk("m0_q", q, 4'b0101);

        // reset in the first DRIVE cycle of a B->A transfer
        req = 1'b1; wr = 1'b0; mask = 4'b1111; din = 4'b1111;
        @(negedge clk);
        chk("mid_driving", gba, 0);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_gab", gab, 1);
        chk("mid_gba", gba, 1);
        chk("mid_dir", dir, 4'b0000);
        chk("mid_q", q, 4'b0000);
        chk("mid_done", done, 0);
        // request accepted on the first edge after reset drops
        rst = 1'b0; req = 1'b1; wr = 1'b1; mask = 4'b0011;
        @(negedge clk);
        chk("post_rst_accept", busy, 1);
        req = 1'b0;
        repeat (8) @(negedge clk);

        // req held high: back-to-back transfers, same then alternating direction
        req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wr = 1'b1; mask = 4'($urandom); din = 4'($urandom);
            @(negedge clk);
        end
        for (int c = 0; c < 40; c++) begin
            wr = ~wr; mask = 4'($urandom); din = 4'($urandom);
            @(negedge clk);
        end

        // randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            req  = ($urandom_range(0, 2) != 0);
            wr   = 1'($urandom);
            mask = 4'($urandom);
            din  = 4'($urandom);
            rst  = ($urandom_range(0, 96) == 0);
            @(negedge clk);
        end
        rst = 1'b0; req = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
